// File: rtl/layer_out_serializer.sv
// Gathers one output word per neuron lane into a capture bank, then streams the
// completed frame one word per cycle. The two banks let the next frame fill while this one streams.
module layer_out_serializer #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_valid,
  output logic                    o_last,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned DW = dataWidth;
  localparam int unsigned CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NN-1:0]          mask_q, mask_d;
  logic [NN-1:0][DW-1:0]  cap_q, cap_d;
  logic [NN-1:0][DW-1:0]  out_q, out_d;
  logic [DW-1:0]          o_data_q, o_data_d;
  logic                   o_valid_q, o_valid_d;
  logic                   o_last_q, o_last_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic [NN-1:0]          mask_now;
  logic                   full;
  logic                   free;
  logic                   xfer;

  // Capture bank fill and the frame hand-off into the output bank.
  always_comb begin
    mask_now  = mask_q | i_valid;
    full      = &mask_now;
    free      = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_IDX));
    xfer      = full && free;
    overrun_d = overrun_q | (|(mask_q & i_valid));
    for (int unsigned k = 0; k < NN; k++) begin
      cap_d[k] = (i_valid[k] && !mask_q[k]) ? i_data[k*DW +: DW] : cap_q[k];
    end
    // A frame that is full but not yet free keeps its mask set, so it stays pending.
    mask_d = xfer ? '0 : mask_now;
    out_d  = xfer ? cap_d : out_q;
  end

  // Next-state logic; outputs are precomputed from the next state so they can be registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_IDX) begin
          cnt_d = cnt_q + CW'(1);
        end else if (xfer) begin
          cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    o_valid_d = (state_d == SHIFT);
    busy_d    = (state_d == SHIFT);
    o_data_d  = o_valid_d ? out_d[cnt_d] : '0;
    o_last_d  = o_valid_d && (cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      out_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      out_q     <= out_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: directed scenarios with literal expectations plus
// randomized lane traffic checked every cycle against a frame/queue model.
module tb_layer_out_serializer;

  localparam int unsigned NN = 4;
  localparam int unsigned DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NN-1:0]     i_valid;
  logic [NN*DW-1:0]  i_data;
  logic [DW-1:0]     o_data;
  logic              o_valid;
  logic              o_last;
  logic              busy;
  logic              overrun;

  int n_vec = 0;
  int n_err = 0;

  layer_out_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: lanes latch once per frame; complete frames become a queue of words.
  logic [NN-1:0] m_mask;
  logic [DW-1:0] m_cap [NN];
  logic [DW:0]   m_q [$];
  logic          e_valid, e_last, e_ovr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    m_mask  = '0;
    for (int k = 0; k < NN; k++) m_cap[k] = '0;
    m_q.delete();
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_ovr   = 1'b0;
    e_data  = '0;
  endtask

  task automatic model_step();
    logic [DW:0] w;
    for (int k = 0; k < NN; k++) begin
      if (i_valid[k]) begin
        if (m_mask[k]) e_ovr = 1'b1;
        else begin
          m_cap[k]  = i_data[k*DW +: DW];
          m_mask[k] = 1'b1;
        end
      end
    end
    // Nothing left to show after the current word means a new frame may start next cycle.
    if ((&m_mask) && (m_q.size() == 0)) begin
      for (int k = 0; k < NN; k++) m_q.push_back({(k == NN - 1), m_cap[k]});
      m_mask = '0;
    end
    if (m_q.size() > 0) begin
      w       = m_q.pop_front();
      e_valid = 1'b1;
      e_data  = w[DW-1:0];
      e_last  = w[DW];
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        n_vec++;
        if (o_valid !== e_valid || o_last !== e_last || busy !== e_valid ||
            overrun !== e_ovr || (e_valid && o_data !== e_data)) begin
          n_err++;
          $display("FAIL stream t=%0t: got v=%b d=%h l=%b busy=%b ov=%b, expected v=%b d=%h l=%b busy=%b ov=%b",
                   $time, o_valid, o_data, o_last, busy, overrun,
                   e_valid, e_data, e_last, e_valid, e_ovr);
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [DW-1:0] d, input logic last);
    chk1({nm, "_valid"}, o_valid, 1'b1);
    chk16({nm, "_data"}, o_data, d);
    chk1({nm, "_last"}, o_last, last);
  endtask

  task automatic chk_quiet(input string nm);
    chk1({nm, "_valid"}, o_valid, 1'b0);
    chk1({nm, "_busy"}, busy, 1'b0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [NN-1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    i_valid = v;
    i_data  = {d3, d2, d1, d0};
  endtask

  task automatic idle_in();
    i_valid = '0;
    i_data  = {$urandom(), $urandom()};
  endtask

  initial begin
    idle_in();
    step(2);
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_last", o_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk16("rst_data", o_data, 16'h0000);
    #2 rst = 1'b1;
    step(1);

    // All lanes in one cycle.
    put(4'b1111, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    step(1); idle_in();
    chk_word("all_w0", 16'h0011, 1'b0);
    step(1); chk_word("all_w1", 16'h0022, 1'b0);
    step(1); chk_word("all_w2", 16'h0033, 1'b0);
    step(1); chk_word("all_w3", 16'h0044, 1'b1);
    step(1); chk_quiet("all_done");
    step(2);

    // Staggered arrival.
    put(4'b0100, 16'h0, 16'h0, 16'hA002, 16'h0);
    step(1); idle_in(); chk_quiet("stag_t1");
    step(1); chk_quiet("stag_t2");
    step(1); put(4'b0001, 16'hA000, 16'h0, 16'h0, 16'h0);
    step(1); idle_in(); chk_quiet("stag_t4");
    step(1); put(4'b1010, 16'h0, 16'hA001, 16'h0, 16'hA003); chk_quiet("stag_t5");
    step(1); idle_in();
    chk_word("stag_w0", 16'hA000, 1'b0);
    step(1); chk_word("stag_w1", 16'hA001, 1'b0);
    step(1); chk_word("stag_w2", 16'hA002, 1'b0);
    step(1); chk_word("stag_w3", 16'hA003, 1'b1);
    step(3);

    // Back-to-back: frame B completes on frame A's last word.
    put(4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
    step(1);
    put(4'b0111, 16'hB000, 16'hB001, 16'hB002, 16'h0);
    chk_word("b2b_a0", 16'hC000, 1'b0);
    step(1); idle_in();
    step(2);
    chk_word("b2b_a3", 16'hC003, 1'b1);
    put(4'b1000, 16'h0, 16'h0, 16'h0, 16'hB003);
    step(1); idle_in();
    chk_word("b2b_b0", 16'hB000, 1'b0);
    step(1); chk_word("b2b_b1", 16'hB001, 1'b0);
    step(1); chk_word("b2b_b2", 16'hB002, 1'b0);
    step(1); chk_word("b2b_b3", 16'hB003, 1'b1);
    step(1); chk_quiet("b2b_done");
    step(2);

    // Pending: frame E completes while D shows word 1.
    put(4'b1111, 16'hD000, 16'hD001, 16'hD002, 16'hD003);
    step(1); idle_in();
    step(1);
    chk_word("pend_d1", 16'hD001, 1'b0);
    put(4'b1111, 16'hE000, 16'hE001, 16'hE002, 16'hE003);
    step(1); idle_in();
    step(1); chk_word("pend_d3", 16'hD003, 1'b1);
    step(1); chk_word("pend_e0", 16'hE000, 1'b0);
    step(1); chk_word("pend_e1", 16'hE001, 1'b0);
    step(1); chk_word("pend_e2", 16'hE002, 1'b0);
    step(1); chk_word("pend_e3", 16'hE003, 1'b1);
    chk1("pend_overrun", overrun, 1'b0);
    step(1); chk_quiet("pend_done");
    step(2);

    // Duplicate pulse on lane 1: first word wins, overrun sticks.
    put(4'b0010, 16'h0, 16'h1111, 16'h0, 16'h0);
    step(1);
    put(4'b0010, 16'h0, 16'h2222, 16'h0, 16'h0);
    step(1); idle_in();
    chk1("dup_overrun", overrun, 1'b1);
    step(1);
    put(4'b1101, 16'hF000, 16'h0, 16'hF002, 16'hF003);
    step(1); idle_in();
    chk_word("dup_w0", 16'hF000, 1'b0);
    step(1); chk_word("dup_w1", 16'h1111, 1'b0);
    step(1); chk_word("dup_w2", 16'hF002, 1'b0);
    step(1); chk_word("dup_w3", 16'hF003, 1'b1);
    chk1("dup_overrun_hold", overrun, 1'b1);
    step(3);

    // Async reset mid-stream, with a partial next frame already captured.
    put(4'b1111, 16'h7000, 16'h7001, 16'h7002, 16'h7003);
    step(1);
    put(4'b0111, 16'h8000, 16'h8001, 16'h8002, 16'h0);
    step(1); idle_in();
    chk_word("rstm_w1", 16'h7001, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk1("rstm_valid", o_valid, 1'b0);
    chk1("rstm_last", o_last, 1'b0);
    chk1("rstm_busy", busy, 1'b0);
    chk1("rstm_overrun", overrun, 1'b0);
    step(2);
    #2 rst = 1'b1;
    step(1);
    put(4'b1000, 16'h0, 16'h0, 16'h0, 16'h9003);
    step(1); idle_in();
    chk_quiet("rstm_mask_clear");
    step(1); chk_quiet("rstm_mask_clear2");
    put(4'b0111, 16'h9000, 16'h9001, 16'h9002, 16'h0);
    step(1); idle_in();
    chk_word("rstm_w0", 16'h9000, 1'b0);
    step(1); chk_word("rstm_w1b", 16'h9001, 1'b0);
    step(1); chk_word("rstm_w2", 16'h9002, 1'b0);
    step(1); chk_word("rstm_w3", 16'h9003, 1'b1);
    step(2);

    // Randomized lane traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [NN-1:0] v;
      for (int k = 0; k < NN; k++) v[k] = ($urandom_range(0, 2) == 0);
      i_valid = v;
      i_data  = {$urandom(), $urandom()};
      step(1);
    end
    idle_in();
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
